direct_mapped_dcache: RTL
=========================

DIRECT_MAPPED_DCACHE -- requirements
Module: direct_mapped_dcache

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have CPU-side ports: is_input_valid in 1 request strobe; addr in 32 byte address; mem_read in 1; mem_write in 1; din in 32 store word.
REQ-004 SHALL have CPU-side outputs: is_ready out 1 accepting requests; is_output_valid out 1 completion pulse; dout out 32 load word; is_hit out 1 request hit.
REQ-005 SHALL have memory-side ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_write out 1; mem_req_addr out 32 line-aligned; mem_req_wdata out 128; mem_resp_valid in 1; mem_resp_rdata in 128.
REQ-006 SHALL have parameters: NUM_SETS, default 16, number of lines; LINE_WORDS, default 4, words per line (both fixed powers of two).

Function
REQ-007 SHALL be direct-mapped, write-back and write-allocate. Address split: tag[31:8], index[7:4], word[3:2]; addr[1:0] ignored.
REQ-008 SHALL accept a request only when is_input_valid && is_ready; is_input_valid while is_ready is low SHALL be ignored.
REQ-009 SHALL implement FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE->COMPARE on accept.
- COMPARE->IDLE on hit.
- COMPARE->WRITEBACK on miss with a dirty victim.
- COMPARE->ALLOCATE on miss with a clean or invalid victim.
- WRITEBACK->ALLOCATE on the write handshake.
- ALLOCATE->COMPARE on mem_resp_valid.
REQ-010 SHALL hold is_ready high only in IDLE.
REQ-011 SHALL latch addr, din, mem_read and mem_write at accept; later changes to these inputs SHALL NOT affect the request in flight.
REQ-012 Hit latency: is_output_valid SHALL pulse for exactly one cycle, in the cycle after accept, and is_ready SHALL be high again in the cycle after that.
REQ-013 SHALL drive is_hit high with is_output_valid only if the first COMPARE of the request hit; the completion that follows a refill SHALL report is_hit=0.
REQ-014 On a load completion, dout SHALL hold the addressed word; dout is don't-care otherwise.
REQ-015 A store SHALL write din into the addressed word, set the line dirty and valid, and pulse is_output_valid.
REQ-016 mem_read and mem_write both high SHALL be treated as a store; both low SHALL complete as a no-op hit without touching the arrays.
REQ-017 SHALL hold each memory request until mem_req_ready.
- WRITEBACK: mem_req_write=1, victim line address, victim data.
- ALLOCATE: mem_req_write=0, requested line address.
REQ-018 mem_resp_valid outside ALLOCATE SHALL be ignored. A refill SHALL load the full line, set it valid and clear its dirty bit.

Reset
REQ-019 Reset SHALL put the FSM in IDLE and clear all valid and dirty bits; tag and data contents are unspecified.
REQ-020 Reset SHALL drive outputs to: is_ready=1, is_output_valid=0, is_hit=0, dout=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0.
REQ-021 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transaction: mem_req_valid low the next cycle, and no array update.

Configuration
REQ-022 With DCACHE_STATS_EN defined, the module SHALL add outputs hit_count and miss_count, 32 bits each, zeroed by reset.
- Each counter SHALL increment once per completed request, per REQ-013.
- Each counter SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 Without DCACHE_STATS_EN, the counters and their ports SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Package dcache_pkg SHALL hold the FSM state enum, the tag/index/offset width constants, and the line-size constant.
REQ-025 Tag, valid, dirty and data storage SHALL live in one sub-module, dcache_line_array, with a single read port and a single write port.

Verification
REQ-026 Bench SHALL cover a cold load: after reset, load 0x0000_0104 with memory returning line {D,C,B,A} -> one mem read at 0x0000_0100, then is_output_valid=1, is_hit=0, dout=B.
REQ-027 Bench SHALL cover hit after fill: load 0x0000_0108 -> is_output_valid in the cycle after accept, is_hit=1, dout=C, no memory request.
REQ-028 Bench SHALL cover dirty eviction: store 0xDEADBEEF to 0x0000_0100, then load 0x0000_1100.
- Required: one mem write at 0x0000_0100 with word0=0xDEADBEEF.
- Then: one mem read at 0x0000_1100, and is_hit=0.
REQ-029 Bench SHALL cover backpressure: mem_req_ready held low 5 cycles during ALLOCATE -> mem_req_valid and mem_req_addr stable, is_ready=0 throughout.
REQ-030 Bench SHALL cover reset during ALLOCATE, then a load of the same address -> mem_req_valid drops, and the reload is a miss.
REQ-031 Bench SHALL cover stats, with DCACHE_STATS_EN defined: 1 miss, 3 hits -> miss_count=1, hit_count=3.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-split constants for the direct-mapped data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W    = 4;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/direct_mapped_dcache_if.sv
// Memory-side request/response bus between the data cache (master) and the
// backing memory (slave). Requests carry whole, line-aligned lines.
interface direct_mapped_dcache_if;
  import dcache_pkg::*;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic [LINE_BITS-1:0]  mem_req_wdata;
  logic                  mem_resp_valid;
  logic [LINE_BITS-1:0]  mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/dcache_line_array.sv
// Tag, valid, dirty and data storage for the cache: one asynchronous read
// port and one synchronous write port that always marks the line valid.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int LINE_W   = 128,
  localparam int IDX_W   = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_dirty,
  input  logic [LINE_W-1:0] wr_data
);

  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  // NOTE: tag/data arrays are deliberately not reset so they map onto plain
  // RAM; a cleared valid bit makes their stale contents unobservable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

endmodule

// File: rtl/direct_mapped_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a 4-state FSM.
// Define DCACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module direct_mapped_dcache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_input_valid,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WORD_W-1:0]        din,
  output logic                     is_ready,
  output logic                     is_output_valid,
  output logic [WORD_W-1:0]        dout,
  output logic                     is_hit,
  direct_mapped_dcache_if.master   mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int LINE_W = LINE_WORDS * WORD_W;

  state_t                 state;
  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_W-1:0]     req_idx;
  logic [WORD_SEL_W-1:0]  req_word;
  logic [WORD_W-1:0]      req_din;
  logic                   req_read;
  logic                   req_write;
  logic                   missed;

  logic [TAG_W-1:0]       rd_tag;
  logic                   rd_valid;
  logic                   rd_dirty;
  logic [LINE_W-1:0]      rd_data;
  logic                   wr_en;
  logic                   wr_dirty;
  logic [LINE_W-1:0]      wr_data;
  logic [LINE_W-1:0]      store_line;

  logic tag_match;
  logic op_none;
  logic done;
  logic unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  dcache_line_array #(
    .NUM_SETS (NUM_SETS),
    .LINE_W   (LINE_W)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .rd_index (req_idx),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (req_idx),
    .wr_tag   (req_tag),
    .wr_dirty (wr_dirty),
    .wr_data  (wr_data)
  );

  // Both strobes low is a no-op that completes as a hit without a lookup.
  assign tag_match = rd_valid && (rd_tag == req_tag);
  assign op_none   = !req_read && !req_write;
  assign done      = (state == COMPARE) && (op_none || tag_match);

  assign is_ready        = (state == IDLE);
  assign is_output_valid = done;
  assign is_hit          = done && !missed;
  assign dout            = (done && req_read && !req_write)
                         ? rd_data[req_word*WORD_W +: WORD_W] : '0;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    store_line = rd_data;
    store_line[req_word*WORD_W +: WORD_W] = req_din;
    wr_en    = 1'b0;
    wr_dirty = 1'b0;
    wr_data  = store_line;
    if (!reset) begin
      if (done && req_write) begin
        wr_en    = 1'b1;
        wr_dirty = 1'b1;
      end else if (state == ALLOCATE && mem.mem_resp_valid) begin
        wr_en   = 1'b1;
        wr_data = mem.mem_resp_rdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      missed            <= 1'b0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_write <= 1'b0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_input_valid) begin
            req_tag   <= addr[ADDR_W-1 -: TAG_W];
            req_idx   <= addr[OFFSET_W +: INDEX_W];
            req_word  <= addr[2 +: WORD_SEL_W];
            req_din   <= din;
            req_read  <= mem_read;
            req_write <= mem_write;
            missed    <= 1'b0;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (done) begin
            state <= IDLE;
          end else begin
            missed            <= 1'b1;
            mem.mem_req_valid <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state             <= WRITEBACK;
              mem.mem_req_write <= 1'b1;
              mem.mem_req_addr  <= line_addr(rd_tag, req_idx);
              mem.mem_req_wdata <= rd_data;
            end else begin
              state             <= ALLOCATE;
              mem.mem_req_write <= 1'b0;
              mem.mem_req_addr  <= line_addr(req_tag, req_idx);
              mem.mem_req_wdata <= '0;
            end
          end
        end
        WRITEBACK: begin
          // The refill request follows directly; mem_req_valid stays high.
          if (mem.mem_req_ready) begin
            state             <= ALLOCATE;
            mem.mem_req_write <= 1'b0;
            mem.mem_req_addr  <= line_addr(req_tag, req_idx);
            mem.mem_req_wdata <= '0;
          end
        end
        ALLOCATE: begin
          if (mem.mem_req_ready || mem.mem_resp_valid) begin
            mem.mem_req_valid <= 1'b0;
          end
          if (mem.mem_resp_valid) begin
            state <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (done) begin
      if (missed) miss_count <= miss_count + 32'd1;
      else        hit_count  <= hit_count + 32'd1;
    end
  end
`endif

endmodule
